// File: rtl/id_stage_p.sv
// Decode stage: IF/ID register, instruction decode, prioritised operand forwarding,
// load-use interlock and branch resolution. Define ID_INST_BUF_EN to hold the SRAM word across stalls.
module id_stage_p #(
    parameter int FWD_N   = 3,
    parameter int STALL_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  flush,
    output logic                  stallreq,
    input  logic [32:0]           if_to_id_bus,
    input  logic [31:0]           inst_sram_rdata,
    input  logic [37:0]           wb_to_rf_bus,
    input  logic [FWD_N-1:0]      fwd_we,
    input  logic [5*FWD_N-1:0]    fwd_waddr,
    input  logic [32*FWD_N-1:0]   fwd_wdata,
    input  logic                  ex_is_load,
    output logic [158:0]          id_to_ex_bus,
    output logic [32:0]           br_bus
);
    logic        r_ce;
    logic [31:0] r_pc;
    logic [31:0] r_rf [32];
    logic [31:0] w_inst_raw, w_inst;

    // Only the IF/ID and ID/EX stop flags matter to this stage.
    logic w_unused;
    assign w_unused = ^{stall[STALL_W-1:3], stall[0]};

    always_ff @(posedge clk) begin
        if (rst || flush)              {r_ce, r_pc} <= '0;
        else if (stall[1] && !stall[2]) {r_ce, r_pc} <= '0;
        else if (!stall[1])            {r_ce, r_pc} <= if_to_id_bus;
    end

    always_ff @(posedge clk) begin
        if (wb_to_rf_bus[37]) r_rf[wb_to_rf_bus[36:32]] <= wb_to_rf_bus[31:0];
    end

`ifdef ID_INST_BUF_EN
    logic [31:0] r_buf;
    logic        r_buf_vld;
    always_ff @(posedge clk) begin
        if (rst || flush || !stall[2]) begin
            r_buf     <= '0;
            r_buf_vld <= 1'b0;
        end else if (!r_buf_vld) begin
            r_buf     <= inst_sram_rdata;
            r_buf_vld <= 1'b1;
        end
    end
    assign w_inst_raw = r_buf_vld ? r_buf : inst_sram_rdata;
`else
    assign w_inst_raw = inst_sram_rdata;
`endif

    assign w_inst = r_ce ? w_inst_raw : 32'd0;

    logic [5:0]  w_op, w_fn;
    logic [4:0]  w_rs, w_rt, w_rd, w_sa;
    logic [15:0] w_imm;
    assign w_op  = w_inst[31:26];
    assign w_rs  = w_inst[25:21];
    assign w_rt  = w_inst[20:16];
    assign w_rd  = w_inst[15:11];
    assign w_sa  = w_inst[10:6];
    assign w_fn  = w_inst[5:0];
    assign w_imm = w_inst[15:0];

    // Gate R-type on ce so the forced all-zero word does not decode as sll.
    logic w_rtype, w_addu, w_subu, w_and, w_or, w_xor, w_sll, w_jr;
    logic w_ori, w_lui, w_addiu, w_lw, w_sw, w_beq, w_bne, w_j, w_jal, w_ralu;
    assign w_rtype = r_ce && (w_op == 6'h00);
    assign w_addu  = w_rtype && (w_fn == 6'h21);
    assign w_subu  = w_rtype && (w_fn == 6'h23);
    assign w_and   = w_rtype && (w_fn == 6'h24);
    assign w_or    = w_rtype && (w_fn == 6'h25);
    assign w_xor   = w_rtype && (w_fn == 6'h26);
    assign w_sll   = w_rtype && (w_fn == 6'h00);
    assign w_jr    = w_rtype && (w_fn == 6'h08);
    assign w_ori   = (w_op == 6'h0D);
    assign w_lui   = (w_op == 6'h0F);
    assign w_addiu = (w_op == 6'h09);
    assign w_lw    = (w_op == 6'h23);
    assign w_sw    = (w_op == 6'h2B);
    assign w_beq   = (w_op == 6'h04);
    assign w_bne   = (w_op == 6'h05);
    assign w_j     = (w_op == 6'h02);
    assign w_jal   = (w_op == 6'h03);
    assign w_ralu  = w_addu | w_subu | w_and | w_or | w_xor | w_sll;

    logic [11:0] w_alu_op;
    logic [2:0]  w_src1;
    logic [3:0]  w_src2;
    logic [4:0]  w_rf_waddr;
    logic        w_rf_we;
    assign w_alu_op = {w_addu | w_addiu | w_lw | w_sw | w_jal, w_subu, 2'b00,
                       w_and, 1'b0, w_or | w_ori, w_xor, w_sll, 2'b00, w_lui};
    assign w_src1   = {w_sll, w_jal,
                       w_addu | w_subu | w_and | w_or | w_xor | w_ori | w_addiu | w_lw | w_sw};
    assign w_src2   = {w_ori, w_jal, w_lui | w_addiu | w_lw | w_sw, w_ralu};
    assign w_rf_waddr = w_ralu ? w_rd :
                        w_jal  ? 5'd31 :
                        (w_ori | w_lui | w_addiu | w_lw) ? w_rt : 5'd0;
    assign w_rf_we  = (w_ralu | w_ori | w_lui | w_addiu | w_lw | w_jal) && (w_rf_waddr != 5'd0);

    // Ascending priority: the youngest matching source overrides older ones.
    logic [31:0] w_rs_val, w_rt_val;
    always_comb begin
        w_rs_val = r_rf[w_rs];
        w_rt_val = r_rf[w_rt];
        for (int i = FWD_N - 1; i >= 0; i--) begin
            if (fwd_we[i] && (fwd_waddr[5*i +: 5] == w_rs)) w_rs_val = fwd_wdata[32*i +: 32];
            if (fwd_we[i] && (fwd_waddr[5*i +: 5] == w_rt)) w_rt_val = fwd_wdata[32*i +: 32];
        end
        if (w_rs == 5'd0) w_rs_val = 32'd0;
        if (w_rt == 5'd0) w_rt_val = 32'd0;
    end

    logic w_rd_rs, w_rd_rt;
    assign w_rd_rs  = w_addu | w_subu | w_and | w_or | w_xor | w_jr | w_ori | w_addiu |
                      w_lw | w_sw | w_beq | w_bne;
    assign w_rd_rt  = w_ralu | w_sw | w_beq | w_bne;
    assign stallreq = ex_is_load && fwd_we[0] && (fwd_waddr[4:0] != 5'd0) &&
                      ((w_rd_rs && (fwd_waddr[4:0] == w_rs)) ||
                       (w_rd_rt && (fwd_waddr[4:0] == w_rt)));

    logic [31:0] w_pc4, w_br_addr;
    logic        w_eq, w_br_e;
    assign w_pc4     = r_pc + 32'd4;
    assign w_eq      = (w_rs_val == w_rt_val);
    assign w_br_e    = !stallreq && ((w_beq && w_eq) || (w_bne && !w_eq) || w_j || w_jal || w_jr);
    assign w_br_addr = (w_beq | w_bne) ? w_pc4 + {{14{w_imm[15]}}, w_imm, 2'b00} :
                       (w_j | w_jal)   ? {w_pc4[31:28], w_inst[25:0], 2'b00} :
                       w_jr            ? w_rs_val : 32'd0;

    assign br_bus       = {w_br_e, w_br_addr};
    assign id_to_ex_bus = {r_pc, w_inst, w_alu_op, w_src1, w_src2, w_lw | w_sw, {4{w_sw}},
                           w_rf_we, w_rf_waddr, w_lw, w_rs_val, w_rt_val};
endmodule

// File: doc/id_stage_p.md
# id_stage_p

Parametrised decode stage between IF and EX of the 5-stage MIPS pipeline; next generation of the single-port ID block. Registers the IF→ID bus with stall/flush control and decodes an extended instruction set. Resolves operands through N-way prioritised forwarding, interlocks on load-use hazards, and resolves branches/jumps in ID. An optional instruction hold buffer retains the synchronous-SRAM instruction word across stalls.

## Interface
- FWD_N, 3: number of forwarding sources; index 0 = youngest (EX), index FWD_N-1 = oldest (WB); legal 1..4
- STALL_W, 6: stall bus width; bit 1 = IF/ID register, bit 2 = ID/EX register
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stall  in  STALL_W  per-stage stop flags (1 = Stop)
- flush  in  1  squash ID register (exception/redirect)
- stallreq  out  1  load-use interlock request
- if_to_id_bus  in  33  {ce, pc[31:0]}
- inst_sram_rdata  in  32  instruction word; valid the cycle after its PC is in the IF/ID register
- wb_to_rf_bus  in  38  {we, waddr[4:0], wdata[31:0]} regfile write port
- fwd_we  in  FWD_N  forwarding write enables
- fwd_waddr  in  5*FWD_N  forwarding destinations, source i at [5i+4:5i]
- fwd_wdata  in  32*FWD_N  forwarding data, source i at [32i+31:32i]
- ex_is_load  in  1  instruction in EX (source 0) is a load
- id_to_ex_bus  out  159  {pc, inst, alu_op[11:0], sel_alu_src1[2:0], sel_alu_src2[3:0], data_ram_en, data_ram_wen[3:0], rf_we, rf_waddr[4:0], sel_rf_res, rs_val, rt_val}
- br_bus  out  33  {br_e, br_addr[31:0]}

## Operation
- IF/ID register priority: rst → 0; flush → 0; stall[1]=Stop & stall[2]=NoStop → 0 (bubble); stall[1]=NoStop → load if_to_id_bus; else hold.
- ce=0 forces decoded inst to 0 (nop): rf_we, data_ram_en, br_e all 0.
- Decoded: addu, subu, and, or, xor, sll, ori, lui, addiu, lw, sw, beq, bne, j, jal, jr. Anything else → nop.
- alu_op bit order {add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui}; lw/sw/addiu/addu/jal use add.
- src1: [0] rs (R-type except sll, ori, addiu, lw, sw), [1] pc (jal), [2] sa zero-ext (sll). src2: [0] rt (R-type), [1] imm sign-ext (lui, addiu, lw, sw), [2] 32'd8 (jal), [3] imm zero-ext (ori).
- lw: data_ram_en=1, wen=0, sel_rf_res=1. sw: data_ram_en=1, wen=4'b1111, rf_we=0.
- rf_waddr: rd (R-type), rt (I-type ALU, lw), 31 (jal). rf_we forced 0 when rf_waddr=0.
- Operand value: first source i (ascending) with fwd_we[i] & waddr=reg; else regfile. Register 0 always reads 0, never forwarded.
- Load-use: stallreq=1 when ce & ex_is_load & fwd_we[0] & fwd_waddr[0]≠0 & matches a register the instruction reads (rs: all but lui/j/jal/sll; rt: R-type, sw, beq, bne).
- Branch: br_e = ce & ~stallreq & (beq&eq | bne&~eq | j | jal | jr). br_addr: beq/bne pc+4+(sext(imm)<<2); j/jal {pc+4[31:28], index, 2'b00}; jr rs_val; others 0. No delay-slot squash here.

## Timing
- Latency 1 cycle: if_to_id_bus registered; id_to_ex_bus, br_bus, stallreq combinational from register, inst and forwarding inputs.
- Reset: register 0, hold buffer empty, so outputs = pc 0, inst 0, all controls 0, stallreq 0, br_bus 0.
- Regfile write and WB forwarding same cycle: forwarding wins (same data).
- stallreq does not gate the register itself; top-level stall controller asserts stall[1]=Stop, stall[2]=NoStop... no: stall[2]=Stop for ID hold, producing EX bubble downstream.
- flush mid-stall: register and hold buffer cleared next edge; stallreq drops.

## Configuration
- ID_INST_BUF_EN defined: 32-bit hold buffer + valid flag. On an edge with stall[2]=Stop and buffer empty, capture inst_sram_rdata; inst = valid ? buffer : inst_sram_rdata. Cleared on rst, flush, or any edge with stall[2]=NoStop.
- Undefined: inst = inst_sram_rdata always; IF must re-present the word during stalls.

## Test plan
- Reset: rst=1 two cycles → id_to_ex_bus=0, br_bus=0, stallreq=0.
- Forward priority: addu $3,$1,$2 with fwd 0 ($1=0x11), fwd 2 ($1=0x33) → rs_val=0x11; fwd to $0 with 0xFF → rs_val=0.
- Load-use: ex_is_load=1, fwd_waddr[0]=5, inst addu $6,$5,$7 → stallreq=1, br_e=0; ex_is_load=0 next → stallreq=0.
- Branch: beq pc=0x1000, imm=0x0004, equal operands → br_bus={1,0x1014}; bne same → br_e=0; jal index 0x10 pc=0xBFC00000 → br_addr=0xB0000040, rf_waddr=31.
- Hold buffer (ID_INST_BUF_EN): ori word present, stall[2]=Stop 3 cycles while inst_sram_rdata changes to 0xDEADBEEF → inst stays ori.
- Flush: flush=1 during stall → next cycle pc=0, inst=0, stallreq=0.
